// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 round-key generator: forward keys for encrypt, reverse keys for decrypt.
// Build option: define AES128_KS_PARALLEL_SBOX_EN for four S-boxes and a 1-cycle step.
package aes128_type_pkg;
    typedef enum logic {
        ENCRYPT = 1'b0,
        DECRYPT = 1'b1
    } mode_t;
endpackage

module aes128_key_schedule
    import aes128_type_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  mode_t        mode_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic         next_i,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         done_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {~x, 3'b000};
        return SBOX_T[idx +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        unique case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t       state, state_n;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    mode_t        mode_q;
    logic         prep_q;
    logic         fwd;
    logic         final_rnd;
    logic         step_last;
    logic [31:0]  t_word;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  rc_word;
    logic [127:0] fwd_key;
    logic [127:0] bwd_key;
    logic         valid_d, busy_d, done_d;

    // Forward steps during decrypt prep or encrypt; otherwise invert
    assign fwd       = prep_q | (mode_q == ENCRYPT);
    assign final_rnd = (mode_q == ENCRYPT) ? (round_q == 4'd10)
                                           : (round_q == 4'd0);
    // Forward uses old w3; backward needs the recovered w3 = w7 ^ w6
    assign t_word    = fwd ? key_q[127:96]
                           : key_q[127:96] ^ key_q[95:64];
    assign rot_word  = {t_word[7:0], t_word[31:8]};
    assign rc_word   = {24'h0, rcon(fwd ? round_q + 4'd1 : round_q)};

`ifdef AES128_KS_PARALLEL_SBOX_EN
    assign sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                        sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    assign step_last = 1'b1;
`else
    logic [1:0]  cnt_q;
    logic [23:0] sub_q;
    logic [7:0]  sbox_out;

    assign sbox_out  = sbox(rot_word[{cnt_q, 3'b000} +: 8]);
    assign sub_word  = {sbox_out, sub_q};
    assign step_last = (cnt_q == 2'd3);

    // Byte counter walks the shared S-box over RotWord, collecting bytes 0..2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            sub_q <= 24'h0;
        end else if (state == CALC) begin
            cnt_q <= cnt_q + 2'd1;
            unique case (cnt_q)
                2'd0:    sub_q[7:0]   <= sbox_out;
                2'd1:    sub_q[15:8]  <= sbox_out;
                2'd2:    sub_q[23:16] <= sbox_out;
                default: ;
            endcase
        end else begin
            cnt_q <= 2'd0;
        end
    end
`endif

    // One forward and one inverse expansion step from the current key
    always_comb begin
        fwd_key[31:0]   = key_q[31:0] ^ sub_word ^ rc_word;
        fwd_key[63:32]  = key_q[63:32] ^ fwd_key[31:0];
        fwd_key[95:64]  = key_q[95:64] ^ fwd_key[63:32];
        fwd_key[127:96] = key_q[127:96] ^ fwd_key[95:64];
        bwd_key[127:96] = key_q[127:96] ^ key_q[95:64];
        bwd_key[95:64]  = key_q[95:64] ^ key_q[63:32];
        bwd_key[63:32]  = key_q[63:32] ^ key_q[31:0];
        bwd_key[31:0]   = key_q[31:0] ^ sub_word ^ rc_word;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: start wins in READY, CALC ignores requests
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start_i)
                    state_n = (mode_i == DECRYPT) ? CALC : READY;
            end
            CALC: begin
                if (step_last)
                    state_n = (prep_q && round_q != 4'd9) ? CALC : READY;
            end
            READY: begin
                if (start_i)
                    state_n = (mode_i == DECRYPT) ? CALC : READY;
                else if (next_i)
                    state_n = final_rnd ? IDLE : CALC;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output decode, taken from the upcoming state so outputs can be registered
    always_comb begin
        valid_d = (state_n == READY);
        busy_d  = (state_n == CALC);
        done_d  = (state == READY) && !start_i && next_i && final_rnd;
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            valid_o <= valid_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
        end
    end

    // Key register, round index and mode: load on start, update on step commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= 128'h0;
            round_q <= 4'd0;
            mode_q  <= ENCRYPT;
            prep_q  <= 1'b0;
        end else if (state != CALC && start_i) begin
            key_q   <= key_i;
            round_q <= 4'd0;
            mode_q  <= mode_i;
            prep_q  <= (mode_i == DECRYPT);
        end else if (state == CALC && step_last) begin
            key_q   <= fwd ? fwd_key : bwd_key;
            round_q <= fwd ? round_q + 4'd1 : round_q - 4'd1;
            prep_q  <= prep_q && (round_q != 4'd9);
        end
    end

    assign round_key_o = key_q;
    assign round_o     = round_q;
endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench for aes128_key_schedule against a FIPS-197 key expansion model.
// Model S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes128_key_schedule;
    import aes128_type_pkg::*;

`ifdef AES128_KS_PARALLEL_SBOX_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 4;
`endif

    localparam logic [127:0] FK  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] FR1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] FRA = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;

    logic         clk = 1'b0;
    logic         rst;
    mode_t        mode_i;
    logic         start_i;
    logic [127:0] key_i;
    logic         next_i;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;

    aes128_key_schedule dut (
        .clk(clk), .rst(rst), .mode_i(mode_i), .start_i(start_i),
        .key_i(key_i), .next_i(next_i), .round_key_o(round_key_o),
        .round_o(round_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [11];
    logic [127:0] exp_keys [11];
    int           exp_round = 0;
    mode_t        exp_mode = ENCRYPT;
    bit           model_live = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_tables();
        logic [7:0] inv, rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                        ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        rcon_tab[0] = 8'h00;
        for (int r = 1; r <= 10; r++) begin
            rcon_tab[r] = rc;
            rc = xtime(rc);
        end
    endtask

    // FIPS-197 KeyExpansion over 44 words, byte n of a word at [n*8+:8]
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t, r;
        for (int i = 0; i < 4; i++) w[i] = k[i*32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                for (int b = 0; b < 4; b++)
                    r[b*8 +: 8] = sbox_tab[t[((b+1)%4)*8 +: 8]];
                t = r ^ {24'h0, rcon_tab[i/4]};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int rr = 0; rr <= 10; rr++)
            exp_keys[rr] = {w[4*rr+3], w[4*rr+2], w[4*rr+1], w[4*rr]};
    endtask

    // Every valid cycle: presented key and index must match the model
    always @(negedge clk) begin
        if (!rst && done_o) done_cnt++;
        if (!rst && model_live && valid_o) begin
            chk("round_idx", round_o, exp_round);
            chk("round_key", round_key_o, exp_keys[exp_round]);
            chk("busy_with_valid", busy_o, 1'b0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int exp_lat, input int pre, input string tag);
        int lows = pre;
        bit busy_ok = 1;
        @(negedge clk);
        while (!valid_o && lows < 200) begin
            if (!busy_o) busy_ok = 0;
            lows++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, lows, exp_lat);
        chk({tag, "_busy"}, busy_ok, 1'b1);
    endtask

    task automatic kick(input mode_t m, input logic [127:0] k, input bit nx);
        mode_i  = m;
        key_i   = k;
        start_i = 1'b1;
        next_i  = nx;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        next_i  = 1'b0;
        expand(k);
        exp_mode   = m;
        exp_round  = (m == ENCRYPT) ? 0 : 10;
        model_live = 1;
    endtask

    task automatic launch(input mode_t m, input logic [127:0] k, input string tag);
        kick(m, k, 1'b0);
        wait_valid((m == ENCRYPT) ? 0 : 10 * STEP, 0, tag);
    endtask

    task automatic step(input string tag);
        next_i = 1'b1;
        @(posedge clk);
        #1;
        next_i = 1'b0;
        exp_round += (exp_mode == ENCRYPT) ? 1 : -1;
        wait_valid(STEP, 0, tag);
    endtask

    task automatic finish_walk(input string tag);
        next_i = 1'b1;
        @(posedge clk);
        #1;
        next_i = 1'b0;
        model_live = 0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {done_o, valid_o}, 2'b10);
        @(negedge clk);
        chk({tag, "_done_end"}, {done_o, valid_o, busy_o}, 3'b000);
    endtask

    task automatic walk(input mode_t m, input logic [127:0] k, input string tag);
        launch(m, k, tag);
        for (int i = 0; i < 10; i++) begin
            idle($urandom_range(0, 2));
            step(tag);
        end
        finish_walk(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lows;
        logic [127:0] k2;
        rst = 1'b1;
        mode_i = ENCRYPT;
        start_i = 1'b0;
        next_i = 1'b0;
        key_i = '0;
        build_tables();
        chk("model_sbox_00", sbox_tab[0], 8'h63);
        chk("model_sbox_53", sbox_tab[8'h53], 8'hed);
        expand(FK);
        chk("model_fips_r1", exp_keys[1], FR1);
        chk("model_fips_r10", exp_keys[10], FRA);
        idle(2);
        chk("reset_state", {valid_o, busy_o, done_o, round_o, round_key_o}, '0);
        rst = 1'b0;
        idle(2);

        // FIPS-197 encrypt walk
        launch(ENCRYPT, FK, "fips_enc_start");
        chk("fips_enc_r0", round_key_o, FK);
        step("fips_enc_step");
        chk("fips_enc_r1", round_key_o, FR1);
        for (int i = 0; i < 9; i++) step("fips_enc_step");
        chk("fips_enc_r10", {round_o, round_key_o}, {4'd10, FRA});
        finish_walk("fips_enc");

        // FIPS-197 decrypt walk
        idle(1);
        launch(DECRYPT, FK, "fips_dec_start");
        chk("fips_dec_r10", {round_o, round_key_o}, {4'd10, FRA});
        for (int i = 0; i < 10; i++) step("fips_dec_step");
        chk("fips_dec_r0", {round_o, round_key_o}, {4'd0, FK});
        finish_walk("fips_dec");

        // start+next together in READY restarts without done
        idle(1);
        launch(ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, "rs_start");
        step("rs_step");
        step("rs_step");
        k2 = {$urandom, $urandom, $urandom, $urandom};
        base = done_cnt;
        kick(ENCRYPT, k2, 1'b1);
        wait_valid(0, 0, "restart");
        chk("restart_round", round_o, 4'd0);
        idle(1);
        chk("restart_no_done", done_cnt, base);

        // start/next during CALC are ignored
        next_i = 1'b1;
        @(posedge clk);
        #1;
        next_i = 1'b0;
        exp_round = 1;
        @(negedge clk);
        chk("calc_busy", {busy_o, valid_o}, 2'b10);
        mode_i = DECRYPT;
        key_i = ~k2;
        start_i = 1'b1;
        next_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        next_i = 1'b0;
        mode_i = ENCRYPT;
        lows = 1;
        @(negedge clk);
        while (!valid_o && lows < 200) begin
            lows++;
            @(negedge clk);
        end
        chk("calc_ignore_latency", lows, STEP);
        chk("calc_ignore_key", {round_o, round_key_o}, {4'd1, exp_keys[1]});
        for (int i = 0; i < 9; i++) step("ci_step");
        finish_walk("ci");

        // Reset in the middle of decrypt preparation
        idle(1);
        base = done_cnt;
        kick(DECRYPT, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        idle(20);
        chk("mid_prep_busy", {busy_o, valid_o}, 2'b10);
        #2;
        rst = 1'b1;
        model_live = 0;
        #1;
        chk("async_reset", {valid_o, busy_o, done_o, round_o, round_key_o}, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        chk("reset_no_done", done_cnt, base);
        walk(ENCRYPT, {$urandom, $urandom, $urandom, $urandom}, "post_rst");

        // Randomised walks in both directions
        for (int n = 0; n < 12; n++) begin
            idle($urandom_range(0, 3));
            walk(($urandom_range(0, 1) == 1) ? DECRYPT : ENCRYPT,
                 {$urandom, $urandom, $urandom, $urandom}, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
